// File: rtl/fixed_pkg.sv
// Signed fixed-point saturation helpers shared by the dense layer and the loss stage.
// Values are carried sign-extended in a 32-bit container; num_w must stay below 31.
package fixed_pkg;

    localparam int WIDE_W = 32;

    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t max_value_pos(input int num_w);
        wide_t one;
        one = 1;
        return (one <<< (num_w - 1)) - one;
    endfunction

    function automatic wide_t max_value_neg(input int num_w);
        wide_t one;
        one = 1;
        return -(one <<< (num_w - 1));
    endfunction

    // Operands fit in num_w bits, so the wide sum never wraps and a range clamp
    // is equivalent to the same-sign-in / different-sign-out overflow test.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int num_w);
        wide_t s;
        s = a + b;
        if (s > max_value_pos(num_w)) return max_value_pos(num_w);
        if (s < max_value_neg(num_w)) return max_value_neg(num_w);
        return s;
    endfunction

    function automatic wide_t sat_neg(input wide_t a, input int num_w);
        if (a == max_value_neg(num_w)) return max_value_pos(num_w);
        return -a;
    endfunction

    function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int num_w);
        return sat_add(a, sat_neg(b, num_w), num_w);
    endfunction

endpackage

// File: rtl/loss_gradient.sv
// Output error stage: serial per-output gradient (target - output) >>> LR_SHIFT
// and saturated squared-error loss through the shared multiplier.
//
// state    | meaning
// IDLE     | waiting for start, ready_out high
// DIFF     | compute saturated difference for element k, write its gradient
// MULT     | square via shared multiplier, accumulate loss when delay hits 0
// FINALIZE | raise done for one cycle, return to IDLE
module loss_gradient
    import fixed_pkg::*;
#(
    parameter int INT_W      = 8,
    parameter int FRAC_W     = 8,
    parameter int OUTPUTS    = 1,
    parameter int LR_SHIFT   = 4,
    parameter int MULT_DELAY = 0,
    parameter int NUM_W      = INT_W + FRAC_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            start,
    input  logic [OUTPUTS-1:0][NUM_W-1:0]   net_out,
    input  logic [OUTPUTS-1:0][NUM_W-1:0]   target,
    output logic [OUTPUTS-1:0][NUM_W-1:0]   grad_out,
    output logic [NUM_W-1:0]                loss,
    output logic                            mult_en,
    output logic [NUM_W-1:0]                mult_v1,
    output logic [NUM_W-1:0]                mult_v2,
    output logic                            mult_shift,
    input  logic [NUM_W-1:0]                mult_res,
    output logic                            ready_out,
    output logic                            done
);

    localparam int K_W   = $clog2(OUTPUTS + 1);
    localparam int DLY_W = (MULT_DELAY > 0) ? $clog2(MULT_DELAY + 1) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DIFF     = 2'd1;
    localparam logic [1:0] S_MULT     = 2'd2;
    localparam logic [1:0] S_FINALIZE = 2'd3;

    logic [1:0]                     state;
    logic [K_W-1:0]                 k;
    logic [DLY_W-1:0]               dly;
    logic [NUM_W-1:0]               diff_q;
    logic [NUM_W-1:0]               loss_q;
    logic [OUTPUTS-1:0][NUM_W-1:0]  grad_q;
    logic                           mult_en_q;
    logic                           done_q;

    logic [NUM_W-1:0]               sel_target;
    logic [NUM_W-1:0]               sel_net;
    wide_t                          diff_wide;
    wide_t                          loss_wide;
    logic signed [NUM_W-1:0]        diff_c;
    logic [NUM_W-1:0]               grad_c;
    logic [NUM_W-1:0]               loss_next;

    // Operands are read live; upstream holds them stable for the whole run.
    always_comb begin
        sel_target = '0;
        sel_net    = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (k == K_W'(i)) begin
                sel_target = target[i];
                sel_net    = net_out[i];
            end
        end
    end

    always_comb begin
        diff_wide = sat_sub({{(WIDE_W-NUM_W){sel_target[NUM_W-1]}}, sel_target},
                            {{(WIDE_W-NUM_W){sel_net[NUM_W-1]}}, sel_net}, NUM_W);
        diff_c    = diff_wide[NUM_W-1:0];
        grad_c    = diff_c >>> LR_SHIFT;
        loss_wide = sat_add({{(WIDE_W-NUM_W){loss_q[NUM_W-1]}}, loss_q},
                            {{(WIDE_W-NUM_W){mult_res[NUM_W-1]}}, mult_res}, NUM_W);
        loss_next = loss_wide[NUM_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            dly       <= '0;
            diff_q    <= '0;
            loss_q    <= '0;
            grad_q    <= '0;
            mult_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        loss_q <= '0;
                        k      <= '0;
                        state  <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    for (int i = 0; i < OUTPUTS; i++) begin
                        if (k == K_W'(i)) grad_q[i] <= grad_c;
                    end
                    diff_q    <= diff_c;
                    mult_en_q <= 1'b1;
                    dly       <= DLY_W'(MULT_DELAY);
                    state     <= S_MULT;
                end
                S_MULT: begin
                    if (dly == '0) begin
                        loss_q    <= loss_next;
                        mult_en_q <= 1'b0;
                        if (k == K_W'(OUTPUTS - 1)) begin
                            state <= S_FINALIZE;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= S_DIFF;
                        end
                    end else begin
                        dly <= dly - DLY_W'(1);
                    end
                end
                S_FINALIZE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign grad_out   = grad_q;
    assign loss       = loss_q;
    assign mult_en    = mult_en_q;
    assign mult_v1    = mult_en_q ? diff_q : '0;
    assign mult_v2    = mult_en_q ? diff_q : '0;
    assign mult_shift = 1'b0;
    assign ready_out  = (state == S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_loss_gradient.sv
// Directed bench: two instances (zero and two-cycle multiplier latency) share stimulus
// and each gets its own saturating multiplier model.
module tb_loss_gradient;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              start;
    logic [1:0][15:0]  net_out;
    logic [1:0][15:0]  target;

    logic [1:0][15:0]  grad0, grad2;
    logic [15:0]       loss0, loss2;
    logic              men0, men2;
    logic [15:0]       v1_0, v2_0, v1_2, v2_2;
    logic              msh0, msh2;
    logic [15:0]       mres0, mres2;
    logic              rdy0, rdy2;
    logic              done0, done2;

    logic [15:0]       pipe1 = '0;
    logic [15:0]       pipe2 = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    loss_gradient #(.INT_W(8), .FRAC_W(8), .OUTPUTS(2), .LR_SHIFT(4), .MULT_DELAY(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .net_out(net_out), .target(target), .grad_out(grad0), .loss(loss0),
        .mult_en(men0), .mult_v1(v1_0), .mult_v2(v2_0), .mult_shift(msh0),
        .mult_res(mres0), .ready_out(rdy0), .done(done0)
    );

    loss_gradient #(.INT_W(8), .FRAC_W(8), .OUTPUTS(2), .LR_SHIFT(4), .MULT_DELAY(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .net_out(net_out), .target(target), .grad_out(grad2), .loss(loss2),
        .mult_en(men2), .mult_v1(v1_2), .mult_v2(v2_2), .mult_shift(msh2),
        .mult_res(mres2), .ready_out(rdy2), .done(done2)
    );

    function automatic logic [15:0] mul_sat(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = (32'(signed'(a)) * 32'(signed'(b))) >>> 8;
        if (p > 32'sd32767)  return 16'h7FFF;
        if (p < -32'sd32768) return 16'h8000;
        return p[15:0];
    endfunction

    assign mres0 = mul_sat(v1_0, v2_0);
    assign mres2 = pipe2;

    always @(posedge clk) begin
        pipe1 <= mul_sat(v1_2, v2_2);
        pipe2 <= pipe1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input int e, input int lo, input int hi);
        return (e >= lo) && (e <= hi);
    endfunction

    // Runs one computation on both instances; stall drops enable for edges 2..4.
    task automatic run(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] g0, input logic [15:0] g1, input logic [15:0] l,
                       input bit poke_start, input bit stall);
        int s;
        logic [15:0] ev0, ev2;
        s = stall ? 3 : 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            chk({tag, " done0"}, done0, e == 5 + s);
            chk({tag, " ready0"}, rdy0, e >= 5 + s);
            chk({tag, " done2"}, done2, e == 9 + s);
            chk({tag, " ready2"}, rdy2, e >= 9 + s);
            ev0 = in_win(e, 1, 1 + s) ? d0 : (in_win(e, 3 + s, 3 + s) ? d1 : 16'h0);
            ev2 = in_win(e, 1, 3 + s) ? d0 : (in_win(e, 5 + s, 7 + s) ? d1 : 16'h0);
            chk({tag, " v1_0"}, v1_0, ev0);
            chk({tag, " v2_0"}, v2_0, ev0);
            chk({tag, " v1_2"}, v1_2, ev2);
            chk({tag, " v2_2"}, v2_2, ev2);
            if (stall && e == 1) enable = 1'b0;
            if (stall && e == 4) enable = 1'b1;
            if (poke_start && e == 1) start = 1'b1;
            if (poke_start && e == 2) start = 1'b0;
        end
        chk({tag, " grad0[0]"}, grad0[0], g0);
        chk({tag, " grad0[1]"}, grad0[1], g1);
        chk({tag, " loss0"}, loss0, l);
        chk({tag, " grad2[0]"}, grad2[0], g0);
        chk({tag, " grad2[1]"}, grad2[1], g1);
        chk({tag, " loss2"}, loss2, l);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        target[0] = 16'h0200; target[1] = 16'h0000;
        net_out[0] = 16'h0100; net_out[1] = 16'h0100;
        #1;
        chk("rst ready", rdy0, 1'b1);
        chk("rst done", done0, 1'b0);
        chk("rst mult_en", men0, 1'b0);
        chk("rst loss", loss0, 16'h0);
        chk("rst grad", grad0, 32'h0);
        chk("rst shift", msh0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run("basic", 16'h0100, 16'hFF00, 16'h0010, 16'hFFF0, 16'h0200, 1'b0, 1'b0);

        enable = 1'b0;
        start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en0 ready", rdy0, 1'b1);
            chk("en0 loss", loss0, 16'h0200);
            chk("en0 done", done0, 1'b0);
        end
        start  = 1'b0;
        enable = 1'b1;
        tick();
        chk("en0 after ready", rdy0, 1'b1);

        run("busy_start", 16'h0100, 16'hFF00, 16'h0010, 16'hFFF0, 16'h0200, 1'b1, 1'b0);
        run("stall", 16'h0100, 16'hFF00, 16'h0010, 16'hFFF0, 16'h0200, 1'b0, 1'b1);

        target[0] = 16'h7F00; target[1] = 16'h0000;
        net_out[0] = 16'h8000; net_out[1] = 16'h0000;
        run("sat", 16'h7FFF, 16'h0000, 16'h07FF, 16'h0000, 16'h7FFF, 1'b0, 1'b0);

        target[0] = 16'h0200; target[1] = 16'h0000;
        net_out[0] = 16'h0100; net_out[1] = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre-rst mult_en", men0, 1'b1);
        chk("pre-rst loss", loss0, 16'h0100);
        reset = 1'b1;
        #1;
        chk("arst grad0", grad0, 32'h0);
        chk("arst loss0", loss0, 16'h0);
        chk("arst mult_en0", men0, 1'b0);
        chk("arst ready0", rdy0, 1'b1);
        chk("arst grad2", grad2, 32'h0);
        chk("arst ready2", rdy2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst done0", done0, 1'b0);
            chk("arst done2", done2, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post-rst done0", done0, 1'b0);
            chk("post-rst ready0", rdy0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/loss_gradient.md
Name: loss_gradient

Overview:
- Output-side error stage. It sits directly downstream of the last dense layer's forward outputs and directly upstream of that layer's backward inputs.
- After a forward pass it serially compares each network output with its target and produces the per-output backprop gradient (target − output) >>> LR_SHIFT.
- It also accumulates the saturated squared-error loss using the shared fixed-point multiplier.
- Its ready_out drives the layer's ready_b_in.

Parameters:
- INT_W, 8, integer bits of the signed fixed-point number.
- FRAC_W, 8, fraction bits.
- OUTPUTS, 1, number of network outputs handled.
- LR_SHIFT, 4, arithmetic right shift applied to the difference (learning-rate scale).
- MULT_DELAY, 0, cycles from operands on mult_v1/mult_v2 to a valid mult_res.
- NUM_W, INT_W+FRAC_W, number width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  clock enable; when low, all state freezes.
- start  in  1  begin a loss/gradient computation; sampled only in IDLE.
- net_out  in  NUM_W x OUTPUTS  signed forward outputs of the last layer.
- target  in  NUM_W x OUTPUTS  signed expected values.
- grad_out  out  NUM_W x OUTPUTS  signed gradients, fed to the layer's inputs_b.
- loss  out  NUM_W  signed saturated sum of squared differences.
- mult_en  out  1  shared multiplier request.
- mult_v1  out  NUM_W  multiplier operand 1; 0 when mult_en=0.
- mult_v2  out  NUM_W  multiplier operand 2; 0 when mult_en=0.
- mult_shift  out  1  tied to 0.
- mult_res  in  NUM_W  signed Q(INT.FRAC) product.
- ready_out  out  1  high when not busy.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (async, high) values:
  - state=IDLE; all counters 0.
  - grad_out all 0, loss=0.
  - mult_en=0, done=0, diff register 0.
  - ready_out=1.
- States: IDLE, DIFF, MULT, FINALIZE. All transitions occur only when enable=1.
- IDLE:
  - On start: clear loss to 0, clear element counter k to 0, go to DIFF.
  - grad_out is not cleared; it is overwritten element by element.
- DIFF (1 cycle):
  - diff = satsub(target[k], net_out[k]); grad_out[k] <= diff >>> LR_SHIFT.
  - Register diff, set mult_en=1, load delay counter with MULT_DELAY, go to MULT.
- MULT (MULT_DELAY+1 cycles):
  - mult_v1=mult_v2=registered diff, held stable throughout.
  - On the cycle the delay counter is 0: loss <= satadd(loss, mult_res) and mult_en <= 0.
  - If k == OUTPUTS−1, go to FINALIZE; otherwise k++ and go to DIFF.
- FINALIZE (1 cycle): done=1, go to IDLE.
- Latency: start sampled at edge 0 → done high for the cycle after edge OUTPUTS*(MULT_DELAY+2)+1. ready_out is high again in that same cycle.
- Saturation:
  - satadd/satsub clamp to MAX_POS {0,1…1} or MAX_NEG {1,0…0} on signed overflow.
  - Overflow test is same-sign operands with a different-sign result; for subtraction, add the negated operand.
  - Negating MAX_NEG saturates to MAX_POS.
- Square is non-negative. mult_res is trusted as supplied by the multiplier, and the loss add still uses satadd.
- net_out and target are read live in DIFF. They must be stable from start until done; this is the upstream's responsibility.
- Boundary behaviour:
  - start while busy: ignored.
  - start with enable=0: ignored.
  - enable low mid-operation: the whole FSM stalls, including the delay counter, and operands stay held. The result equals the unstalled result and completes later by the stall count.
  - reset mid-operation: immediately returns to reset values; no done pulse.
  - OUTPUTS=1: a single DIFF/MULT pair.
- Counter k is $clog2(OUTPUTS+1) bits wide. The delay counter is $clog2(MULT_DELAY+1) bits wide, minimum 1.

Decomposition:
- Shared package (fixed_pkg):
  - NUM_W-parameterised MAX_VALUE_POS/MAX_VALUE_NEG constants.
  - Saturating add function; saturating sub built on add with saturated negate.
  - Shared by this block and the dense layer.
- State enum is local to this module.
- No sub-module is required; the single FSM plus a register array is natural.

Test Plan (INT_W=8, FRAC_W=8, OUTPUTS=2, LR_SHIFT=4; multiplier model = sat((a*b)>>>8)):
- MULT_DELAY=0; target={0x0200,0x0000}, net_out={0x0100,0x0100}, pulse start → grad_out={0x0010,0xFFF0}, loss=0x0200, done 1 cycle after edge 5, ready_out low during edges 1–5.
- target={0x7F00,0}, net_out={0x8000,0} → diff clamped 0x7FFF, grad_out[0]=0x07FF, loss=0x7FFF (saturated), grad_out[1]=0.
- start pulsed at edge 2 while busy, and start with enable=0 in IDLE → no restart and no state change; results as in scenario 1.
- reset asserted asynchronously at edge 3 of a run → grad_out, loss=0, mult_en=0, ready_out=1 immediately; no done pulse.
- MULT_DELAY=2, scenario 1 data → mult_v1/v2 stable for 3 cycles per element, done after edge 9, same results.
- MULT_DELAY=0, enable low for 3 cycles during MULT of k=0 → done after edge 8, results identical to scenario 1.
